// File: rtl/bcd_stopwatch_game_pkg.sv
// stopwatch_game_pkg: shared definitions for the BCD stopwatch game.
//   state_t        FSM state encoding (IDLE=0, COUNTING=1, FAIL=2, SUCCESS=3)
//   GLYPH_*        active-low gfedcba patterns for the mode glyph position
//   seg7()         BCD digit to active-low gfedcba segment pattern
package stopwatch_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_FAIL     = 2'd2,
        ST_SUCCESS  = 2'd3
    } state_t;

    localparam logic [6:0] GLYPH_UP   = 7'b101_1100;
    localparam logic [6:0] GLYPH_DOWN = 7'b110_0011;
    localparam logic [6:0] GLYPH_F    = 7'b000_1110;
    localparam logic [6:0] GLYPH_S    = 7'b001_0010;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = 7'b111_1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_game_if.sv
// bcd_stopwatch_game_if: button/preset bundle feeding the stopwatch game.
//   digit_sel  preset-digit select, bit0 = units (several bits may be set)
//   inc_p, dec_p, start_p, stop_p, dir_p  single-cycle debounced pulses
//   master: button source; slave: stopwatch core
interface bcd_stopwatch_game_if #(
    parameter int NUM_DIGITS = 3
);
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  inc_p;
    logic                  dec_p;
    logic                  start_p;
    logic                  stop_p;
    logic                  dir_p;

    modport master (output digit_sel, inc_p, dec_p, start_p, stop_p, dir_p);
    modport slave  (input  digit_sel, inc_p, dec_p, start_p, stop_p, dir_p);
endinterface

// File: rtl/bcd_stopwatch_game_seg_scan.sv
// seg_scan: multiplexed 7-segment scanner.
//   clk, rst_n   clock, synchronous active-low reset
//   digits_i     BCD digits, [0] = units
//   glyph_i      pattern for the top (mode glyph) position
//   digit_o      active-low one-hot anode enable, registered
//   display_o    active-low gfedcba segments, registered
module seg_scan
    import stopwatch_game_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 10000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_DIGITS-1:0][3:0] digits_i,
    input  logic [6:0]                 glyph_i,
    output logic [NUM_DIGITS:0]        digit_o,
    output logic [6:0]                 display_o
);
    localparam int AW = NUM_DIGITS + 1;
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int PW = $clog2(NUM_DIGITS + 2);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(NUM_DIGITS);

    logic [SW-1:0] scan_q, scan_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_d;
    logic [AW-1:0] anode_d;

    // Both output registers are loaded from the next position so the anode
    // and segment pattern always switch on the same edge.
    always_comb begin
        scan_d = scan_q + 1'b1;
        pos_d  = pos_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end
        cur_digit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (pos_d == PW'(i)) cur_digit = digits_i[i];
        end
        seg_d   = (pos_d == POS_LAST) ? glyph_i : seg7(cur_digit);
        anode_d = ~(AW'(1) << pos_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q    <= '0;
            pos_q     <= '0;
            digit_o   <= ~AW'(1);
            display_o <= seg7(4'd0);
        end else begin
            scan_q    <= scan_d;
            pos_q     <= pos_d;
            digit_o   <= anode_d;
            display_o <= seg_d;
        end
    end
endmodule

// File: rtl/bcd_stopwatch_game.sv
// bcd_stopwatch_game: reaction game on a BCD stopwatch. The player presets
// the digits, starts counting and tries to stop within WIN counts of the
// start value.
//   clk, rst_n  clock, synchronous active-low reset
//   btn         button bundle (bcd_stopwatch_game_if.slave)
//   DIGIT       active-low one-hot anode enable, MSB = mode glyph
//   DISPLAY     active-low segments gfedcba
//   led         status LEDs
//   state_o     current FSM state
// Optional: STOPWATCH_GAME_BLINK_EN makes the result LEDs blink
// (on/off/on/off/on, BLINK_DIV cycles each) instead of holding steady.
module bcd_stopwatch_game
    import stopwatch_game_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int TICK_DIV   = 1000000,
    parameter int WIN        = 100,
    parameter int HOLD_TICKS = 3,
    parameter int BLINK_DIV  = 50000000,
    parameter int SCAN_DIV   = 10000,
    parameter int LED_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_stopwatch_game_if.slave btn,
    output logic [NUM_DIGITS:0] DIGIT,
    output logic [6:0]          DISPLAY,
    output logic [LED_W-1:0]    led,
    output logic [1:0]          state_o
);
    localparam int BW = $clog2(10 ** NUM_DIGITS) + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

    typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;
    localparam bcd_t ALL_NINES = {NUM_DIGITS{4'd9}};

    function automatic logic [BW-1:0] to_bin(input bcd_t v);
        logic [BW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            acc = acc * BW'(10) + BW'(v[NUM_DIGITS - 1 - i]);
        return acc;
    endfunction

    function automatic bcd_t bcd_step(input bcd_t v, input logic down);
        bcd_t r;
        logic c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (!down && r[i] == 4'd9)      r[i] = 4'd0;
                else if (down && r[i] == 4'd0)  r[i] = 4'd9;
                else begin
                    r[i] = down ? r[i] - 4'd1 : r[i] + 4'd1;
                    c    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    bcd_t          digits_q, digits_d;
    logic          dir_down_q, dir_down_d;
    logic [BW-1:0] start_q, start_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] end_bin, diff;
    logic          step_due, at_limit;
    logic [6:0]    glyph;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            dir_down_q <= 1'b0;
            start_q    <= '0;
            tick_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            dir_down_q <= dir_down_d;
            start_q    <= start_d;
            tick_q     <= tick_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        dir_down_d = dir_down_q;
        start_d    = start_q;
        tick_d     = tick_q;
        hold_d     = hold_q;
        step_due   = (tick_q == TICK_LAST);
        at_limit   = dir_down_q ? (digits_q == '0) : (digits_q == ALL_NINES);
        end_bin    = to_bin(digits_q);
        diff       = (end_bin >= start_q) ? end_bin - start_q : start_q - end_bin;
        case (state_q)
            ST_IDLE: begin
                if (btn.start_p) begin
                    state_d = ST_COUNTING;
                    start_d = end_bin;
                    tick_d  = '0;
                    hold_d  = '0;
                end else begin
                    if (btn.dir_p) dir_down_d = ~dir_down_q;
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (btn.digit_sel[i]) begin
                            if (btn.inc_p)
                                digits_d[i] = (digits_q[i] == 4'd9) ? 4'd0 : digits_q[i] + 4'd1;
                            else if (btn.dec_p)
                                digits_d[i] = (digits_q[i] == 4'd0) ? 4'd9 : digits_q[i] - 4'd1;
                        end
                    end
                end
            end
            ST_COUNTING: begin
                tick_d = step_due ? '0 : tick_q + 1'b1;
                // stop_p judges the value shown this cycle, so it must
                // take priority over a step falling due on the same edge.
                if (btn.stop_p) begin
                    state_d = (int'(diff) <= WIN) ? ST_SUCCESS : ST_FAIL;
                end else if (step_due) begin
                    if (at_limit) begin
                        state_d = ST_FAIL;
                    end else begin
                        digits_d = bcd_step(digits_q, dir_down_q);
                        if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                if (btn.start_p) state_d = ST_IDLE;
            end
        endcase
    end

`ifdef STOPWATCH_GAME_BLINK_EN
    localparam int KW = $clog2(BLINK_DIV + 1);
    localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_DIV - 1);

    logic [KW-1:0] blink_cnt_q;
    logic [2:0]    blink_ph_q;
    logic          result_entry, in_result, blink_on;

    assign result_entry = (state_q == ST_COUNTING) &&
                          (state_d == ST_SUCCESS || state_d == ST_FAIL);
    assign in_result    = (state_q == ST_SUCCESS || state_q == ST_FAIL);
    // Phases 0,2,4 lit; phase 5 is the terminal dark phase.
    assign blink_on     = ~blink_ph_q[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= '0;
        end else if (result_entry) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= '0;
        end else if (in_result && blink_ph_q != 3'd5) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= blink_ph_q + 3'd1;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        led = '1;
        case (state_q)
            ST_COUNTING: led = (hold_q == HOLD_LAST) ? '0 : '1;
`ifdef STOPWATCH_GAME_BLINK_EN
            ST_SUCCESS,
            ST_FAIL:     led = blink_on ? '1 : '0;
`else
            ST_SUCCESS:  led = '1;
            ST_FAIL:     led = '0;
`endif
            default:     led = '1;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_FAIL:    glyph = GLYPH_F;
            ST_SUCCESS: glyph = GLYPH_S;
            default:    glyph = dir_down_q ? GLYPH_DOWN : GLYPH_UP;
        endcase
    end

    assign state_o = state_q;

    seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_i  (digits_q),
        .glyph_i   (glyph),
        .digit_o   (DIGIT),
        .display_o (DISPLAY)
    );
endmodule

// File: tb/tb_bcd_stopwatch_game.sv
// tb_bcd_stopwatch_game: directed self-checking bench for bcd_stopwatch_game
// (NUM_DIGITS=3, TICK_DIV=4, WIN=5, HOLD_TICKS=2, BLINK_DIV=3, SCAN_DIV=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Honours STOPWATCH_GAME_BLINK_EN for the result-LED expectations.
module tb_bcd_stopwatch_game;

    localparam logic [6:0] G_UP = 7'b101_1100;
    localparam logic [6:0] G_DN = 7'b110_0011;
    localparam logic [6:0] G_F  = 7'b000_1110;
    localparam logic [6:0] G_S  = 7'b001_0010;

    localparam int unsigned K_INC   = 0;
    localparam int unsigned K_DEC   = 1;
    localparam int unsigned K_START = 2;
    localparam int unsigned K_STOP  = 3;
    localparam int unsigned K_DIR   = 4;
    localparam int unsigned K_BOTH  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] DIGIT;
    logic [6:0] DISPLAY;
    logic [7:0] led;
    logic [1:0] state_o;
    int         checks = 0;
    int         failures = 0;

    bcd_stopwatch_game_if #(.NUM_DIGITS(3)) bif ();

    bcd_stopwatch_game #(
        .NUM_DIGITS (3),
        .TICK_DIV   (4),
        .WIN        (5),
        .HOLD_TICKS (2),
        .BLINK_DIV  (3),
        .SCAN_DIV   (2),
        .LED_W      (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (bif),
        .DIGIT   (DIGIT),
        .DISPLAY (DISPLAY),
        .led     (led),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] tb_seg(input int unsigned d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] expw(input logic [6:0] g, input int unsigned h,
                                         input int unsigned t, input int unsigned u);
        return {g, tb_seg(h), tb_seg(t), tb_seg(u)};
    endfunction

    // Called at a falling edge; one rising edge sees the pulse.
    task automatic press(input int unsigned kind, input logic [2:0] sel);
        bif.digit_sel = sel;
        bif.inc_p     = (kind == K_INC || kind == K_BOTH);
        bif.dec_p     = (kind == K_DEC || kind == K_BOTH);
        bif.start_p   = (kind == K_START);
        bif.stop_p    = (kind == K_STOP);
        bif.dir_p     = (kind == K_DIR);
        @(negedge clk);
        bif.inc_p = 1'b0; bif.dec_p = 1'b0; bif.start_p = 1'b0;
        bif.stop_p = 1'b0; bif.dir_p = 1'b0; bif.digit_sel = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presets from 000 (fresh after reset).
    task automatic preset(input int unsigned h, input int unsigned t, input int unsigned u);
        for (int unsigned i = 0; i < h; i++) press(K_INC, 3'b100);
        for (int unsigned i = 0; i < t; i++) press(K_INC, 3'b010);
        for (int unsigned i = 0; i < u; i++) press(K_INC, 3'b001);
    endtask

    // Gathers one pattern per scan position: {glyph, hundreds, tens, units}.
    task automatic scan_capture(output logic [27:0] w);
        logic [3:0] seen;
        logic       bad;
        seen = '0;
        bad  = 1'b0;
        w    = 'x;
        @(negedge clk);
        for (int unsigned n = 0; n < 24 && seen != 4'hF; n++) begin
            case (DIGIT)
                4'b1110: begin w[6:0]   = DISPLAY; seen[0] = 1'b1; end
                4'b1101: begin w[13:7]  = DISPLAY; seen[1] = 1'b1; end
                4'b1011: begin w[20:14] = DISPLAY; seen[2] = 1'b1; end
                4'b0111: begin w[27:21] = DISPLAY; seen[3] = 1'b1; end
                default: bad = 1'b1;
            endcase
            @(negedge clk);
        end
        if (bad) w = 'x;
    endtask

    task automatic test_reset;
        logic [27:0] w;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (led !== 8'hFF) begin failures++; $display("FAIL reset_led got %h want ff", led); end
        checks++; if (DIGIT !== 4'b1110) begin failures++; $display("FAIL reset_digit got %b want 1110", DIGIT); end
        checks++; if (DISPLAY !== 7'b100_0000) begin failures++; $display("FAIL reset_display got %b want 1000000", DISPLAY); end
        rst_n = 1'b1;
        scan_capture(w);
        checks++; if (w !== expw(G_UP, 0, 0, 0)) begin failures++; $display("FAIL reset_scan got %h want %h", w, expw(G_UP, 0, 0, 0)); end
    endtask

    task automatic test_preset;
        logic [27:0] w;
        repeat (3) press(K_DEC, 3'b001);
        press(K_INC, 3'b110);
        press(K_DIR, 3'b000);
        scan_capture(w);
        checks++; if (w !== expw(G_DN, 1, 1, 7)) begin failures++; $display("FAIL preset_117 got %h want %h", w, expw(G_DN, 1, 1, 7)); end
        checks++; if (state_o !== 2'd0 || led !== 8'hFF) begin failures++; $display("FAIL preset_idle got st=%0d led=%h want st=0 led=ff", state_o, led); end
        press(K_BOTH, 3'b001);
        scan_capture(w);
        checks++; if (w !== expw(G_DN, 1, 1, 8)) begin failures++; $display("FAIL inc_wins got %h want %h", w, expw(G_DN, 1, 1, 8)); end
    endtask

    task automatic test_up_carry;
        logic [27:0] w;
        logic [7:0]  exp_led;
        do_reset;
        preset(0, 9, 5);
        press(K_START, 3'b000);
        repeat (21) @(negedge clk);
        press(K_STOP, 3'b000);          // sampled after 5 steps: 100, diff 5
        checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL carry_success_state got %0d want 3", state_o); end
        for (int unsigned i = 0; i < 18; i++) begin
`ifdef STOPWATCH_GAME_BLINK_EN
            exp_led = ((i / 3) < 5 && ((i / 3) % 2) == 0) ? 8'hFF : 8'h00;
`else
            exp_led = 8'hFF;
`endif
            checks++; if (led !== exp_led) begin failures++; $display("FAIL success_led[%0d] got %h want %h", i, led, exp_led); end
            @(negedge clk);
        end
        scan_capture(w);
        checks++; if (w !== expw(G_S, 1, 0, 0)) begin failures++; $display("FAIL carry_scan got %h want %h", w, expw(G_S, 1, 0, 0)); end
    endtask

    task automatic test_stop_boundary;
        logic [27:0] w;
        logic [7:0]  exp_led;
        do_reset;
        preset(1, 0, 0);
        press(K_START, 3'b000);
        for (int unsigned i = 0; i < 25; i++) begin
            exp_led = (i < 8) ? 8'hFF : 8'h00;
            checks++; if (led !== exp_led) begin failures++; $display("FAIL hold_led[%0d] got %h want %h", i, led, exp_led); end
            @(negedge clk);
        end
        press(K_STOP, 3'b000);          // value 106, diff 6
        checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL over_win_state got %0d want 2", state_o); end
`ifdef STOPWATCH_GAME_BLINK_EN
        exp_led = 8'hFF;
`else
        exp_led = 8'h00;
`endif
        checks++; if (led !== exp_led) begin failures++; $display("FAIL fail_led got %h want %h", led, exp_led); end
        scan_capture(w);
        checks++; if (w !== expw(G_F, 1, 0, 6)) begin failures++; $display("FAIL over_win_scan got %h want %h", w, expw(G_F, 1, 0, 6)); end
        press(K_START, 3'b000);
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL restart_state got %0d want 0", state_o); end
        scan_capture(w);
        checks++; if (w !== expw(G_UP, 1, 0, 6)) begin failures++; $display("FAIL restart_keep got %h want %h", w, expw(G_UP, 1, 0, 6)); end

        do_reset;
        preset(1, 0, 0);
        press(K_START, 3'b000);
        repeat (23) @(negedge clk);
        press(K_STOP, 3'b000);          // same edge as 105->106 step
        checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL stop_vs_step_state got %0d want 3", state_o); end
        scan_capture(w);
        checks++; if (w !== expw(G_S, 1, 0, 5)) begin failures++; $display("FAIL stop_vs_step_scan got %h want %h", w, expw(G_S, 1, 0, 5)); end
    endtask

    task automatic test_down_terminal;
        logic [27:0] w;
        do_reset;
        preset(0, 0, 3);
        press(K_DIR, 3'b000);
        press(K_START, 3'b000);
        repeat (13) @(negedge clk);
        press(K_STOP, 3'b000);          // 000 after 3 steps, diff 3
        checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL down_success_state got %0d want 3", state_o); end
        scan_capture(w);
        checks++; if (w !== expw(G_S, 0, 0, 0)) begin failures++; $display("FAIL down_success_scan got %h want %h", w, expw(G_S, 0, 0, 0)); end
        press(K_START, 3'b000);
        scan_capture(w);
        checks++; if (w !== expw(G_DN, 0, 0, 0)) begin failures++; $display("FAIL down_dir_kept got %h want %h", w, expw(G_DN, 0, 0, 0)); end
        repeat (3) press(K_INC, 3'b001);
        press(K_START, 3'b000);
        repeat (14) @(negedge clk);
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL terminal_early14 got %0d want 1", state_o); end
        @(negedge clk);
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL terminal_early15 got %0d want 1", state_o); end
        @(negedge clk);
        checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL terminal_state got %0d want 2", state_o); end
        press(K_INC, 3'b111);
        press(K_DIR, 3'b000);
        press(K_STOP, 3'b000);
        press(K_DEC, 3'b111);
        checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL result_ignore_state got %0d want 2", state_o); end
        scan_capture(w);
        checks++; if (w !== expw(G_F, 0, 0, 0)) begin failures++; $display("FAIL terminal_scan got %h want %h", w, expw(G_F, 0, 0, 0)); end
    endtask

    task automatic test_reset_mid;
        logic [27:0] w;
        do_reset;
        preset(0, 4, 0);
        press(K_START, 3'b000);
        repeat (9) @(negedge clk);      // 042 shown, two steps done
        checks++; if (led !== 8'h00) begin failures++; $display("FAIL mid_led got %h want 00", led); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL mid_reset_state got %0d want 0", state_o); end
        checks++; if (led !== 8'hFF) begin failures++; $display("FAIL mid_reset_led got %h want ff", led); end
        checks++; if (DIGIT !== 4'b1110) begin failures++; $display("FAIL mid_reset_digit got %b want 1110", DIGIT); end
        checks++; if (DISPLAY !== 7'b100_0000) begin failures++; $display("FAIL mid_reset_display got %b want 1000000", DISPLAY); end
        rst_n = 1'b1;
        scan_capture(w);
        checks++; if (w !== expw(G_UP, 0, 0, 0)) begin failures++; $display("FAIL mid_reset_scan got %h want %h", w, expw(G_UP, 0, 0, 0)); end
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL mid_reset_stays got %0d want 0", state_o); end
    endtask

    initial begin
        bif.digit_sel = '0;
        bif.inc_p = 1'b0; bif.dec_p = 1'b0; bif.start_p = 1'b0;
        bif.stop_p = 1'b0; bif.dir_p = 1'b0;
        test_reset;
        test_preset;
        test_up_carry;
        test_stop_boundary;
        test_down_terminal;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
